// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 key decoder: event layout, set-2 scancodes, ASCII codes.
package ps2_kbd_pkg;

  localparam int SC_W    = 8;
  localparam int EVT_W   = 10;
  localparam int EXP_BIT = 9;
  localparam int BRK_BIT = 8;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_TAB    = 8'h0D;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_TAB   = 8'h09;
  localparam logic [7:0] ASC_ESC   = 8'h1B;
  localparam logic [7:0] ASC_UP    = 8'h80;
  localparam logic [7:0] ASC_DOWN  = 8'h81;
  localparam logic [7:0] ASC_LEFT  = 8'h82;
  localparam logic [7:0] ASC_RIGHT = 8'h83;

  // Shifted digit row, indexed by the digit value 0..9.
  function automatic logic [7:0] shifted_digit(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'h29;
      4'd1:    c = 8'h21;
      4'd2:    c = 8'h40;
      4'd3:    c = 8'h23;
      4'd4:    c = 8'h24;
      4'd5:    c = 8'h25;
      4'd6:    c = 8'h5E;
      4'd7:    c = 8'h26;
      4'd8:    c = 8'h2A;
      default: c = 8'h28;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational set-2 make-code to ASCII translation. Arrow keys on expanded codes
// are produced only when KEY_ARROW_EN is defined.
module ps2_scan2ascii
  import ps2_kbd_pkg::*;
(
  input  logic       expand,
  input  logic [7:0] scancode,
  input  logic       shift,
  input  logic       ctrl,
  input  logic       caps,
  output logic [7:0] char,
  output logic       hit
);

  logic [4:0] letter;   // 1..26 for a..z, 0 when not a letter
  logic       is_digit;
  logic [3:0] digit;

  always_comb begin
    letter = 5'd0;
    case (scancode)
      8'h1C: letter = 5'd1;
      8'h32: letter = 5'd2;
      8'h21: letter = 5'd3;
      8'h23: letter = 5'd4;
      8'h24: letter = 5'd5;
      8'h2B: letter = 5'd6;
      8'h34: letter = 5'd7;
      8'h33: letter = 5'd8;
      8'h43: letter = 5'd9;
      8'h3B: letter = 5'd10;
      8'h42: letter = 5'd11;
      8'h4B: letter = 5'd12;
      8'h3A: letter = 5'd13;
      8'h31: letter = 5'd14;
      8'h44: letter = 5'd15;
      8'h4D: letter = 5'd16;
      8'h15: letter = 5'd17;
      8'h2D: letter = 5'd18;
      8'h1B: letter = 5'd19;
      8'h2C: letter = 5'd20;
      8'h3C: letter = 5'd21;
      8'h2A: letter = 5'd22;
      8'h1D: letter = 5'd23;
      8'h22: letter = 5'd24;
      8'h35: letter = 5'd25;
      8'h1A: letter = 5'd26;
      default: letter = 5'd0;
    endcase
  end

  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    case (scancode)
      8'h45: digit = 4'd0;
      8'h16: digit = 4'd1;
      8'h1E: digit = 4'd2;
      8'h26: digit = 4'd3;
      8'h25: digit = 4'd4;
      8'h2E: digit = 4'd5;
      8'h36: digit = 4'd6;
      8'h3D: digit = 4'd7;
      8'h3E: digit = 4'd8;
      8'h46: digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

  always_comb begin
    char = 8'h00;
    hit  = 1'b0;
    if (expand) begin
`ifdef KEY_ARROW_EN
      hit = 1'b1;
      case (scancode)
        SC_UP:    char = ASC_UP;
        SC_DOWN:  char = ASC_DOWN;
        SC_LEFT:  char = ASC_LEFT;
        SC_RIGHT: char = ASC_RIGHT;
        default:  hit  = 1'b0;
      endcase
`endif
    end else if (letter != 5'd0) begin
      hit = 1'b1;
      // Ctrl folds letters onto 0x01..0x1A and takes priority over case.
      if (ctrl)              char = {3'b000, letter};
      else if (shift ^ caps) char = 8'h40 + {3'b000, letter};
      else                   char = 8'h60 + {3'b000, letter};
    end else if (is_digit) begin
      hit  = 1'b1;
      char = shift ? shifted_digit(digit) : (8'h30 + {4'h0, digit});
    end else begin
      hit = 1'b1;
      case (scancode)
        SC_SPACE: char = ASC_SPACE;
        SC_ENTER: char = ASC_CR;
        SC_BKSP:  char = ASC_BS;
        SC_TAB:   char = ASC_TAB;
        SC_ESC:   char = ASC_ESC;
        default:  hit  = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Key-event decoder: modifier tracking, one-stage translation pipeline and show-ahead
// character FIFO. Arrow-key output is enabled by defining KEY_ARROW_EN.
module ps2_key_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        key_data,
  input  logic              key_ready,
  output logic [7:0]        ascii_out,
  output logic              ascii_valid,
  input  logic              ascii_pop,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              mod_shift,
  output logic              mod_ctrl,
  output logic              mod_caps
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic       expand, brk;
  logic [7:0] scancode;
  assign expand   = key_data[EXP_BIT];
  assign brk      = key_data[BRK_BIT];
  assign scancode = key_data[SC_W-1:0];

  logic lshift, rshift, lctrl, rctrl, caps, caps_held;
  assign mod_shift = lshift | rshift;
  assign mod_ctrl  = lctrl | rctrl;
  assign mod_caps  = caps;

  logic [7:0] xl_char;
  logic       xl_hit;

  ps2_scan2ascii u_xlate (
    .expand   (expand),
    .scancode (scancode),
    .shift    (mod_shift),
    .ctrl     (mod_ctrl),
    .caps     (mod_caps),
    .char     (xl_char),
    .hit      (xl_hit)
  );

  // Modifier flags; the translator above sees their pre-event values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
      caps      <= 1'b0;
      caps_held <= 1'b0;
    end else if (key_ready) begin
      if (!expand && scancode == SC_LSHIFT) lshift <= !brk;
      if (!expand && scancode == SC_RSHIFT) rshift <= !brk;
      if (scancode == SC_CTRL) begin
        if (expand) rctrl <= !brk;
        else        lctrl <= !brk;
      end
      if (!expand && scancode == SC_CAPS) begin
        if (!brk) begin
          if (!caps_held) caps <= ~caps;
          caps_held <= 1'b1;
        end else begin
          caps_held <= 1'b0;
        end
      end
    end
  end

  logic       stage_vld;
  logic [7:0] stage_char;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld  <= 1'b0;
      stage_char <= 8'h00;
    end else begin
      stage_vld  <= key_ready && !brk && xl_hit;
      stage_char <= xl_char;
    end
  end

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              full, pop_ok, push_ok, drop;

  assign full        = (fifo_count == FULL_CNT);
  assign ascii_valid = (fifo_count != '0);
  assign pop_ok      = ascii_pop && ascii_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok     = stage_vld && (!full || pop_ok);
  assign drop        = stage_vld && full && !pop_ok;
  assign ascii_out   = ascii_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= stage_char;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus random events against a
// queue-based reference model of the keyboard rules.
module tb_ps2_key_decoder;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [9:0]        key_data;
  logic              key_ready;
  logic [7:0]        ascii_out;
  logic              ascii_valid;
  logic              ascii_pop;
  logic [ADDR_W:0]   fifo_count;
  logic              overflow;
  logic              ovf_clr;
  logic              mod_shift, mod_ctrl, mod_caps;

  ps2_key_decoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_data    (key_data),
    .key_ready   (key_ready),
    .ascii_out   (ascii_out),
    .ascii_valid (ascii_valid),
    .ascii_pop   (ascii_pop),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .mod_shift   (mod_shift),
    .mod_ctrl    (mod_ctrl),
    .mod_caps    (mod_caps)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] exp_q[$];
  logic m_ls, m_rs, m_lc, m_rc, m_caps, m_held, m_pend, m_ovf;
  logic [7:0] m_pchar;

  byte   letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                            8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte   digit_sc [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  byte   arrow_sc [4]   = '{8'h75, 8'h72, 8'h6B, 8'h74};
  string shift_row      = ")!@#$%^&*(";

  task automatic model_reset();
    exp_q.delete();
    {m_ls, m_rs, m_lc, m_rc, m_caps, m_held, m_pend, m_ovf} = '0;
    m_pchar = 8'h00;
  endtask

  // Returns {hit, char}
  function automatic logic [8:0] ref_xlate(input logic ex, input logic br, input logic [7:0] sc,
                                           input logic sh, input logic ct, input logic cp);
    if (br) return 9'h000;
    if (ex) begin
`ifdef KEY_ARROW_EN
      for (int i = 0; i < 4; i++)
        if (sc == arrow_sc[i]) return {1'b1, 8'(8'h80 + i)};
`endif
      return 9'h000;
    end
    for (int i = 0; i < 26; i++)
      if (sc == letter_sc[i]) begin
        if (ct)           return {1'b1, 8'(i + 1)};
        else if (sh ^ cp) return {1'b1, 8'("A" + i)};
        else              return {1'b1, 8'("a" + i)};
      end
    for (int i = 0; i < 10; i++)
      if (sc == digit_sc[i]) return sh ? {1'b1, 8'(shift_row[i])} : {1'b1, 8'("0" + i)};
    case (sc)
      8'h29: return 9'h120;
      8'h5A: return 9'h10D;
      8'h66: return 9'h108;
      8'h0D: return 9'h109;
      8'h76: return 9'h11B;
      default: return 9'h000;
    endcase
  endfunction

  task automatic model_edge(input logic kr, input logic [9:0] kd, input logic pp, input logic clr);
    logic pop_ok, push, drop;
    logic [8:0] r;
    logic ex, br;
    logic [7:0] sc;
    ex = kd[9]; br = kd[8]; sc = kd[7:0];
    pop_ok = pp && (exp_q.size() > 0);
    push = 1'b0; drop = 1'b0;
    if (m_pend) begin
      if (exp_q.size() < DEPTH || pop_ok) push = 1'b1;
      else                                drop = 1'b1;
    end
    if (pop_ok) void'(exp_q.pop_front());
    if (push)   exp_q.push_back(m_pchar);
    if (drop)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    r = ref_xlate(ex, br, sc, m_ls | m_rs, m_lc | m_rc, m_caps);
    m_pend  = kr && r[8];
    m_pchar = r[7:0];
    if (kr) begin
      if (!ex && sc == 8'h12) m_ls = !br;
      if (!ex && sc == 8'h59) m_rs = !br;
      if (sc == 8'h14) begin
        if (ex) m_rc = !br;
        else    m_lc = !br;
      end
      if (!ex && sc == 8'h58) begin
        if (!br && !m_held) m_caps = !m_caps;
        m_held = !br;
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] head;
    head = 8'h00;
    if (exp_q.size() > 0) head = exp_q[0];
    check_eq("valid", 16'(ascii_valid), 16'(exp_q.size() > 0));
    check_eq("head", 16'(ascii_out), 16'(head));
    check_eq("count", 16'(fifo_count), 16'(exp_q.size()));
    check_eq("overflow", 16'(overflow), 16'(m_ovf));
    check_eq("shift", 16'(mod_shift), 16'(m_ls | m_rs));
    check_eq("ctrl", 16'(mod_ctrl), 16'(m_lc | m_rc));
    check_eq("caps", 16'(mod_caps), 16'(m_caps));
  endtask

  // One clock: drive at negedge, update model at posedge, compare at next negedge.
  task automatic cyc(input logic kr, input logic [9:0] kd, input logic pp, input logic clr);
    key_ready = kr; key_data = kd; ascii_pop = pp; ovf_clr = clr;
    @(posedge clk);
    model_edge(kr, kd, pp, clr);
    @(negedge clk);
    check_all();
  endtask

  task automatic key(input logic [9:0] kd);
    cyc(1'b1, kd, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 10'h000, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    cyc(1'b0, 10'h000, 1'b1, 1'b0);
  endtask

  function automatic logic [9:0] rand_event();
    logic [7:0] sc;
    logic ex, br;
    case ($urandom_range(0, 9))
      0, 1, 2: sc = letter_sc[$urandom_range(0, 25)];
      3:       sc = digit_sc[$urandom_range(0, 9)];
      4:       sc = arrow_sc[$urandom_range(0, 3)];
      5:       begin
                 case ($urandom_range(0, 4))
                   0: sc = 8'h29; 1: sc = 8'h5A; 2: sc = 8'h66; 3: sc = 8'h0D; default: sc = 8'h76;
                 endcase
               end
      6:       begin
                 case ($urandom_range(0, 3))
                   0: sc = 8'h12; 1: sc = 8'h59; 2: sc = 8'h14; default: sc = 8'h58;
                 endcase
               end
      default: sc = 8'($urandom_range(0, 255));
    endcase
    br = ($urandom_range(0, 2) == 0);
    ex = ($urandom_range(0, 3) == 0);
    if (sc == 8'h12 || sc == 8'h59 || sc == 8'h58) ex = 1'b0;
    return {ex, br, sc};
  endfunction

  initial begin
    rst_n = 1'b0; key_ready = 1'b0; key_data = '0; ascii_pop = 1'b0; ovf_clr = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    check_eq("rst_head", 16'(ascii_out), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Two-clock latency for a single make
    key(10'h01C);
    check_eq("lat1_valid", 16'(ascii_valid), 16'h0000);
    idle(1);
    check_eq("lat2_valid", 16'(ascii_valid), 16'h0001);
    check_eq("lat2_head", 16'(ascii_out), 16'h0061);
    check_eq("lat2_count", 16'(fifo_count), 16'h0001);
    pop1();
    check_eq("pop_count", 16'(fifo_count), 16'h0000);

    // Shift make/break around letters, back-to-back strobes
    key(10'h012); key(10'h01C); key(10'h112); key(10'h01C);
    idle(2);
    check_eq("shift_head0", 16'(ascii_out), 16'h0041);
    pop1();
    check_eq("shift_head1", 16'(ascii_out), 16'h0061);
    pop1();
    check_eq("shift_end", 16'(mod_shift), 16'h0000);

    // CapsLock with typematic repeats
    key(10'h058); key(10'h058); key(10'h058); key(10'h158);
    check_eq("caps_on", 16'(mod_caps), 16'h0001);
    key(10'h01C); idle(1);
    check_eq("caps_letter", 16'(ascii_out), 16'h0041);
    pop1();
    key(10'h012); key(10'h016); key(10'h112); idle(1);
    check_eq("shift_digit", 16'(ascii_out), 16'h0021);
    pop1();
    key(10'h058); key(10'h158);
    check_eq("caps_off", 16'(mod_caps), 16'h0000);

    // Right ctrl on expanded code
    key(10'h214); key(10'h021); idle(1);
    check_eq("ctrl_c", 16'(ascii_out), 16'h0003);
    pop1();
    key(10'h314); key(10'h021); idle(1);
    check_eq("ctrl_rel", 16'(ascii_out), 16'h0063);
    pop1();

    // Fill past DEPTH, then push+pop at full, then clear
    for (int i = 0; i < DEPTH + 1; i++) key(10'h01C);
    idle(2);
    check_eq("fill_count", 16'(fifo_count), 16'(DEPTH));
    check_eq("fill_ovf", 16'(overflow), 16'h0001);
    check_eq("fill_head", 16'(ascii_out), 16'h0061);
    key(10'h032);
    cyc(1'b0, 10'h000, 1'b1, 1'b0);
    check_eq("full_pp_count", 16'(fifo_count), 16'(DEPTH));
    check_eq("full_pp_ovf", 16'(overflow), 16'h0001);
    cyc(1'b0, 10'h000, 1'b0, 1'b1);
    check_eq("ovf_clr", 16'(overflow), 16'h0000);
    for (int i = 0; i < DEPTH; i++) pop1();
    pop1();

    // Arrow key on expanded code
    key(10'h275); idle(1);
`ifdef KEY_ARROW_EN
    check_eq("arrow_head", 16'(ascii_out), 16'h0080);
    pop1();
`else
    check_eq("arrow_none", 16'(fifo_count), 16'h0000);
`endif

    // Randomised traffic
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 9) < 6), rand_event(), ($urandom_range(0, 9) < 4),
          ($urandom_range(0, 19) == 0));
    idle(2);

    // Asynchronous reset with characters queued and keys held
    while (exp_q.size() > 0) pop1();
    key(10'h012); key(10'h014); key(10'h058);
    key(10'h01C); key(10'h032); key(10'h021);
    idle(2);
    check_eq("pre_rst_count", 16'(fifo_count), 16'h0003);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 16'(ascii_valid), 16'h0000);
    check_eq("arst_count", 16'(fifo_count), 16'h0000);
    check_eq("arst_mods", 16'({mod_shift, mod_ctrl, mod_caps}), 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    key(10'h01C); idle(1);
    check_eq("post_rst_head", 16'(ascii_out), 16'h0061);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
